// File: rtl/sd_dat_rx_crc16_if.sv
// Byte-sink side of the SD DAT0 block receiver: line strobe/sample, arm pulse,
// received bytes and end-of-block status.
interface sd_dat_rx_crc16_if;
  logic       bit_en;
  logic       dat_in;
  logic       start;
  logic       busy;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       done;
  logic       crc_ok;
  logic       crc_err;
  logic       timeout;

  modport master (
    output bit_en, dat_in, start,
    input  busy, byte_out, byte_valid, done, crc_ok, crc_err, timeout
  );

  modport slave (
    input  bit_en, dat_in, start,
    output busy, byte_out, byte_valid, done, crc_ok, crc_err, timeout
  );
endinterface

// File: rtl/sd_dat_rx_crc16.sv
// SD single-line data-block receiver: start-bit hunt, MSB-first deserialiser,
// inline CRC16-CCITT (init 0) over the data bits, trailing CRC and end-bit check.
module sd_dat_rx_crc16 #(
  parameter int BLOCK_BYTES  = 512,
  parameter int TIMEOUT_BITS = 1024
) (
  input logic               clk,
  input logic               reset_n,
  sd_dat_rx_crc16_if.slave  bus
);

  localparam int DATA_BITS = BLOCK_BYTES * 8;
  localparam int BIT_W     = $clog2(DATA_BITS + 1);
  localparam int TO_W      = (TIMEOUT_BITS > 1) ? $clog2(TIMEOUT_BITS) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
  localparam logic [TO_W-1:0]  LAST_TO  = TO_W'(TIMEOUT_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_START,
    S_DATA,
    S_CRC,
    S_END
  } state_e;

  state_e             state_q;
  logic [15:0]        crc_q;
  logic [15:0]        rx_crc_q;
  logic [7:0]         sreg_q;
  logic [7:0]         byte_out_q;
  logic [BIT_W-1:0]   bit_cnt_q;
  logic [TO_W-1:0]    to_cnt_q;
  logic [3:0]         crc_cnt_q;
  logic               busy_q;
  logic               byte_valid_q;
  logic               done_q;
  logic               crc_ok_q;
  logic               crc_err_q;
  logic               timeout_q;

  logic [7:0]         sreg_d;
  logic [15:0]        crc_d;
  logic               match_d;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic inv;
    inv = din ^ crc[15];
    return {crc[14:0], 1'b0} ^ (inv ? 16'h1021 : 16'h0000);
  endfunction

  assign sreg_d  = {sreg_q[6:0], bus.dat_in};
  assign crc_d   = crc16_step(crc_q, bus.dat_in);
  // End-bit cycle: the block is good only if the received CRC matches and the line is high.
  assign match_d = (rx_crc_q == crc_q) && bus.dat_in;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      crc_q        <= '0;
      rx_crc_q     <= '0;
      sreg_q       <= '0;
      byte_out_q   <= '0;
      bit_cnt_q    <= '0;
      to_cnt_q     <= '0;
      crc_cnt_q    <= '0;
      busy_q       <= 1'b0;
      byte_valid_q <= 1'b0;
      done_q       <= 1'b0;
      crc_ok_q     <= 1'b0;
      crc_err_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      case (state_q)
        // A bit_en coinciding with start is deliberately not sampled here.
        S_IDLE: begin
          if (bus.start) begin
            state_q   <= S_WAIT_START;
            busy_q    <= 1'b1;
            crc_q     <= '0;
            bit_cnt_q <= '0;
            to_cnt_q  <= '0;
            crc_cnt_q <= '0;
            crc_ok_q  <= 1'b0;
            crc_err_q <= 1'b0;
          end
        end
        S_WAIT_START: begin
          if (bus.bit_en) begin
            if (!bus.dat_in) begin
              state_q <= S_DATA;
            end else if (to_cnt_q == LAST_TO) begin
              state_q   <= S_IDLE;
              busy_q    <= 1'b0;
              timeout_q <= 1'b1;
            end else begin
              to_cnt_q <= to_cnt_q + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (bus.bit_en) begin
            sreg_q    <= sreg_d;
            crc_q     <= crc_d;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q[2:0] == 3'd7) begin
              byte_out_q   <= sreg_d;
              byte_valid_q <= 1'b1;
            end
            if (bit_cnt_q == LAST_BIT) begin
              state_q <= S_CRC;
            end
          end
        end
        S_CRC: begin
          if (bus.bit_en) begin
            rx_crc_q  <= {rx_crc_q[14:0], bus.dat_in};
            crc_cnt_q <= crc_cnt_q + 1'b1;
            if (crc_cnt_q == 4'd15) begin
              state_q <= S_END;
            end
          end
        end
        S_END: begin
          if (bus.bit_en) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            crc_ok_q  <= match_d;
            crc_err_q <= !match_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.byte_out   = byte_out_q;
  assign bus.byte_valid = byte_valid_q;
  assign bus.done       = done_q;
  assign bus.crc_ok     = crc_ok_q;
  assign bus.crc_err    = crc_err_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_sd_dat_rx_crc16.sv
// Scoreboard bench for sd_dat_rx_crc16: a 9-byte/16-strobe instance under directed and
// random blocks, plus a 512-byte instance receiving the all-0xFF reference block.
module tb_sd_dat_rx_crc16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sd_dat_rx_crc16_if bus ();
  sd_dat_rx_crc16_if bus2 ();

  sd_dat_rx_crc16 #(.BLOCK_BYTES(9), .TIMEOUT_BITS(16)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  sd_dat_rx_crc16 #(.BLOCK_BYTES(512), .TIMEOUT_BITS(1024)) dut_big (
    .clk(clk), .reset_n(reset_n), .bus(bus2)
  );

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_bytes[$];
  logic [1:0] exp_stat[$];
  int         exp_to = 0;
  logic [7:0] blk[$];
  logic [1:0] last_stat;

  int         big_bytes = 0;
  int         big_bad = 0;
  int         big_done = 0;
  int         big_to = 0;
  logic [1:0] big_stat = 2'b00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference CRC: remainder of M(x)*x^16 divided by x^16+x^12+x^5+1, by long division.
  function automatic logic [15:0] model_crc();
    bit          msg[$];
    logic [16:0] poly;
    logic [15:0] r;
    int          base;
    poly = 17'h11021;
    foreach (blk[i]) for (int j = 7; j >= 0; j--) msg.push_back(blk[i][j]);
    repeat (16) msg.push_back(1'b0);
    for (int i = 0; i + 16 < msg.size(); i++)
      if (msg[i]) for (int k = 0; k < 17; k++) msg[i+k] = msg[i+k] ^ poly[16-k];
    base = msg.size() - 16;
    for (int k = 0; k < 16; k++) r[15-k] = msg[base+k];
    return r;
  endfunction

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.byte_valid) begin
        chk("valid_done_overlap", 32'(bus.done), 32'd0);
        if (exp_bytes.size() == 0) begin
          checks++; failures++;
          $display("FAIL byte_unexpected: got %02h expected none", bus.byte_out);
        end else chk("byte", 32'(bus.byte_out), 32'(exp_bytes.pop_front()));
      end
      if (bus.done) begin
        if (exp_stat.size() == 0) begin
          checks++; failures++;
          $display("FAIL done_unexpected: got done=1 expected none");
        end else chk("status_ok_err", 32'({bus.crc_ok, bus.crc_err}), 32'(exp_stat.pop_front()));
        chk("busy_at_done", 32'(bus.busy), 32'd0);
      end
      if (bus.timeout) begin
        if (exp_to == 0) begin
          checks++; failures++;
          $display("FAIL timeout_unexpected: got timeout=1 expected none");
        end else begin
          exp_to--;
          chk("busy_at_timeout", 32'(bus.busy), 32'd0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus2.byte_valid) begin
        big_bytes++;
        if (bus2.byte_out !== 8'hFF) big_bad++;
      end
      if (bus2.done) begin
        big_done++;
        big_stat = {bus2.crc_ok, bus2.crc_err};
      end
      if (bus2.timeout) big_to++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic b, input int maxgap);
    int g;
    g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    for (int i = 0; i < g; i++) begin
      bus.bit_en = 1'b0;
      bus.dat_in = 1'($urandom);
      cyc();
    end
    bus.bit_en = 1'b1;
    bus.dat_in = b;
    cyc();
    bus.bit_en = 1'b0;
  endtask

  task automatic strobe2(input logic b);
    bus2.bit_en = 1'b1;
    bus2.dat_in = b;
    cyc();
    bus2.bit_en = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_bytes.size() != 0 || exp_stat.size() != 0 || exp_to != 0) && n < 100) begin
      cyc();
      n++;
    end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL drain_timeout: got %0d bytes/%0d status/%0d timeouts outstanding expected 0",
               exp_bytes.size(), exp_stat.size(), exp_to);
    end
  endtask

  task automatic start_pulse(input logic sbit);
    chk("status_held", 32'({bus.crc_ok, bus.crc_err}), 32'(last_stat));
    bus.start  = 1'b1;
    bus.bit_en = sbit;
    bus.dat_in = 1'b0;
    cyc();
    bus.start  = 1'b0;
    bus.bit_en = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    chk("status_cleared", 32'({bus.crc_ok, bus.crc_err}), 32'd0);
    last_stat = 2'b00;
  endtask

  task automatic send_block(input logic [15:0] crcv, input logic endb, input int pre,
                            input int maxgap, input logic sbit, input logic midstart);
    logic ok;
    ok = (crcv == model_crc()) && endb;
    foreach (blk[i]) exp_bytes.push_back(blk[i]);
    exp_stat.push_back({ok, !ok});
    start_pulse(sbit);
    repeat (pre) strobe(1'b1, maxgap);
    strobe(1'b0, maxgap);
    foreach (blk[i]) begin
      for (int j = 7; j >= 0; j--) begin
        strobe(blk[i][j], maxgap);
        if (midstart && i == 4 && j == 0) begin
          bus.start = 1'b1;
          cyc();
          bus.start = 1'b0;
        end
      end
    end
    for (int j = 15; j >= 0; j--) strobe(crcv[j], maxgap);
    strobe(endb, maxgap);
    chk("done_latency", 32'(bus.done), 32'd1);
    last_stat = {ok, !ok};
    drain();
    chk("busy_after_block", 32'(bus.busy), 32'd0);
  endtask

  task automatic load_ascii();
    blk.delete();
    for (int i = 0; i < 9; i++) blk.push_back(8'(8'h31 + i));
  endtask

  task automatic load_random();
    blk.delete();
    for (int i = 0; i < 9; i++) blk.push_back(8'($urandom));
  endtask

  initial begin
    logic [15:0] crcv;
    bus.bit_en = 1'b0; bus.dat_in = 1'b1; bus.start = 1'b0;
    bus2.bit_en = 1'b0; bus2.dat_in = 1'b1; bus2.start = 1'b0;
    reset_n = 1'b0;
    repeat (3) cyc();
    chk("reset_outputs", 32'({bus.busy, bus.byte_valid, bus.done, bus.crc_ok, bus.crc_err,
                              bus.timeout, bus.byte_out}), 32'd0);
    chk("reset_outputs_big", 32'({bus2.busy, bus2.byte_valid, bus2.done, bus2.crc_ok,
                                  bus2.crc_err, bus2.timeout, bus2.byte_out}), 32'd0);
    reset_n = 1'b1;
    cyc();
    last_stat = 2'b00;

    // "123456789" with good CRC, bad CRC, and good CRC with a low end bit
    load_ascii();
    send_block(16'h31C3, 1'b1, 3, 0, 1'b0, 1'b0);
    send_block(16'h31C2, 1'b1, 0, 0, 1'b0, 1'b0);
    send_block(16'h31C3, 1'b0, 1, 0, 1'b1, 1'b0);

    // Start-bit hunt timeout: 15 high strobes are tolerated, the 16th aborts
    start_pulse(1'b0);
    repeat (15) strobe(1'b1, 3);
    chk("no_timeout_at_15", 32'(bus.timeout), 32'd0);
    chk("busy_at_15", 32'(bus.busy), 32'd1);
    exp_to = 1;
    strobe(1'b1, 3);
    chk("timeout_pulse", 32'(bus.timeout), 32'd1);
    chk("busy_dropped", 32'(bus.busy), 32'd0);
    drain();
    chk("timeout_one_cycle", 32'(bus.timeout), 32'd0);
    load_random();
    send_block(model_crc(), 1'b1, 15, 2, 1'b0, 1'b0);

    // Gapped strobes with an ignored mid-block start
    load_ascii();
    send_block(16'h31C3, 1'b1, 4, 5, 1'b0, 1'b1);

    // Reset 20 bits into a block: two bytes already out, the partial third is lost
    load_ascii();
    start_pulse(1'b0);
    strobe(1'b0, 1);
    exp_bytes.push_back(blk[0]);
    exp_bytes.push_back(blk[1]);
    for (int b = 0; b < 20; b++) strobe(blk[b/8][7-(b%8)], 1);
    drain();
    reset_n = 1'b0;
    #1;
    chk("midblock_reset_outputs", 32'({bus.busy, bus.byte_valid, bus.done, bus.crc_ok,
                                       bus.crc_err, bus.timeout, bus.byte_out}), 32'd0);
    bus.start = 1'b1;
    repeat (2) strobe(1'b0, 0);
    bus.start = 1'b0;
    chk("reset_held_outputs", 32'({bus.busy, bus.byte_valid, bus.done, bus.crc_ok,
                                   bus.crc_err, bus.timeout}), 32'd0);
    reset_n = 1'b1;
    cyc();
    last_stat = 2'b00;
    send_block(16'h31C3, 1'b1, 2, 2, 1'b0, 1'b0);

    // Random blocks: odd runs carry a single flipped CRC bit, one run a low end bit
    for (int r = 0; r < 6; r++) begin
      load_random();
      crcv = model_crc();
      if (r % 2 == 1) crcv = crcv ^ (16'h0001 << $urandom_range(15, 0));
      send_block(crcv, (r == 4) ? 1'b0 : 1'b1, int'($urandom_range(15, 0)),
                 int'($urandom_range(3, 0)), 1'($urandom), 1'b0);
    end

    // 512-byte instance: all-0xFF block against the published CRC
    bus2.start = 1'b1;
    cyc();
    bus2.start = 1'b0;
    chk("big_busy_after_start", 32'(bus2.busy), 32'd1);
    repeat (3) strobe2(1'b1);
    strobe2(1'b0);
    repeat (512 * 8) strobe2(1'b1);
    for (int j = 15; j >= 0; j--) strobe2(((16'h7FA1 >> j) & 16'h1) != 0);
    strobe2(1'b1);
    repeat (3) cyc();
    chk("big_byte_count", 32'(big_bytes), 32'd512);
    chk("big_bad_bytes", 32'(big_bad), 32'd0);
    chk("big_done_count", 32'(big_done), 32'd1);
    chk("big_status", 32'(big_stat), 32'b10);
    chk("big_busy_end", 32'(bus2.busy), 32'd0);
    chk("big_no_timeout", 32'(big_to), 32'd0);

    chk("leftover_bytes", 32'(exp_bytes.size()), 32'd0);
    chk("leftover_status", 32'(exp_stat.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
